// File: rtl/tm_tape_engine.sv
// Clocked Turing-machine engine: register tape, head, state and step counter,
// stepping read -> lookup -> write/move against an external combinational table.
module tm_tape_engine #(
  parameter int unsigned STATE_W    = 3,
  parameter int unsigned SYM_W      = 3,
  parameter int unsigned TAPE_DEPTH = 32,
  parameter int unsigned ADDR_W     = $clog2(TAPE_DEPTH),
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HALT_STATE = 0,
  parameter bit          WRAP       = 1'b0,
  parameter int unsigned MAX_STEPS  = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [SYM_W-1:0]   cfg_wdata,
  input  logic [ADDR_W-1:0]  cfg_raddr,
  output logic [SYM_W-1:0]   cfg_rdata,
  input  logic               start,
  input  logic [STATE_W-1:0] start_state,
  input  logic [ADDR_W-1:0]  start_head,
  input  logic               free_run,
  input  logic               step_req,
  input  logic               abort,
  output logic [STATE_W-1:0] tt_state,
  output logic [SYM_W-1:0]   tt_sym,
  input  logic [STATE_W-1:0] tt_next_state,
  input  logic [SYM_W-1:0]   tt_write_sym,
  input  logic               tt_dir,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [STATE_W-1:0] state,
  output logic [ADDR_W-1:0]  head,
  output logic [CNT_W-1:0]   step_count
);

  localparam logic [ADDR_W-1:0]  HEAD_MAX = ADDR_W'(TAPE_DEPTH - 1);
  localparam logic [STATE_W-1:0] HALT_S   = STATE_W'(HALT_STATE);
  localparam logic [1:0]         CODE_NONE  = 2'd0;
  localparam logic [1:0]         CODE_EDGE  = 2'd1;
  localparam logic [1:0]         CODE_LIMIT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMMIT,
    S_HALTED,
    S_FAULT
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] ns_q, ns_d;
  logic [SYM_W-1:0]   ws_q, ws_d;
  logic               dir_q, dir_d;
  logic [1:0]         code_q, code_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic [SYM_W-1:0]   tape_q [TAPE_DEPTH];
  logic [SYM_W-1:0]   tape_d [TAPE_DEPTH];

  logic at_edge;
  logic off_edge;
  logic limit_hit;

  assign at_edge   = dir_q ? (head_q == HEAD_MAX) : (head_q == '0);
  assign off_edge  = !WRAP && at_edge;
  assign limit_hit = (MAX_STEPS != 0) && ((32'(cnt_q) + 32'd1) == 32'(MAX_STEPS));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    ns_d    = ns_q;
    ws_d    = ws_q;
    dir_d   = dir_q;
    code_d  = code_q;
    tape_d  = tape_q;

    case (fsm_q)
      S_IDLE, S_HALTED, S_FAULT: begin
        // Host write lands before a same-cycle start, so the first lookup sees it.
        if (cfg_we) tape_d[cfg_addr] = cfg_wdata;
        if (abort) begin
          fsm_d  = S_IDLE;
          code_d = CODE_NONE;
        end else if (start) begin
          state_d = start_state;
          head_d  = start_head;
          cnt_d   = '0;
          code_d  = CODE_NONE;
          fsm_d   = (start_state == HALT_S) ? S_HALTED : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (abort) begin
          fsm_d  = S_IDLE;
          code_d = CODE_NONE;
        end else if (free_run || step_req) begin
          ns_d  = tt_next_state;
          ws_d  = tt_write_sym;
          dir_d = tt_dir;
          fsm_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (abort) begin
          fsm_d  = S_IDLE;
          code_d = CODE_NONE;
        end else begin
          tape_d[head_q] = ws_q;
          state_d        = ns_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          // Off-edge moves on a non-wrapping build hold the head even when halting.
          if (!off_edge) head_d = dir_q ? head_q + ADDR_W'(1) : head_q - ADDR_W'(1);
          if (ns_q == HALT_S) begin
            fsm_d = S_HALTED;
          end else if (off_edge) begin
            fsm_d  = S_FAULT;
            code_d = CODE_EDGE;
          end else if (limit_hit) begin
            fsm_d  = S_FAULT;
            code_d = CODE_LIMIT;
          end else begin
            fsm_d = S_LOOKUP;
          end
        end
      end
      default: begin
        fsm_d  = S_IDLE;
        code_d = CODE_NONE;
      end
    endcase

    busy_d   = (fsm_d == S_LOOKUP) || (fsm_d == S_COMMIT);
    halted_d = (fsm_d == S_HALTED);
    fault_d  = (fsm_d == S_FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= S_IDLE;
      state_q  <= '0;
      head_q   <= '0;
      cnt_q    <= '0;
      ns_q     <= '0;
      ws_q     <= '0;
      dir_q    <= 1'b0;
      code_q   <= CODE_NONE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < TAPE_DEPTH; i++) tape_q[i] <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      head_q   <= head_d;
      cnt_q    <= cnt_d;
      ns_q     <= ns_d;
      ws_q     <= ws_d;
      dir_q    <= dir_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      tape_q   <= tape_d;
    end
  end

  assign cfg_rdata  = tape_q[cfg_raddr];
  assign tt_state   = state_q;
  assign tt_sym     = tape_q[head_q];
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign state      = state_q;
  assign head       = head_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_tm_tape_engine.sv
// Bench for tm_tape_engine: three builds (plain, wrapping, 5-step limit) share stimulus;
// directed vectors, hand sequences and random tables checked against a step model.
module tb_tm_tape_engine;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [2:0] cfg_wdata;
  logic [4:0] cfg_raddr;
  logic       start;
  logic [2:0] start_state;
  logic [4:0] start_head;
  logic       free_run;
  logic       step_req;
  logic       abort;

  logic [2:0]  rdata_o [3];
  logic [2:0]  tts     [3];
  logic [2:0]  ttsy    [3];
  logic [6:0]  tt_res  [3];
  logic        busy_o  [3];
  logic        halted_o[3];
  logic        fault_o [3];
  logic [1:0]  code_o  [3];
  logic [2:0]  st_o    [3];
  logic [4:0]  hd_o    [3];
  logic [15:0] cnt_o   [3];

  int         mode;
  logic [2:0] rt_ns  [8][8];
  logic [2:0] rt_ws  [8][8];
  logic       rt_dir [8][8];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  // Table modes: 0 one-shot halt, 1 left-walker, 2 right-moving counter, 3 random table.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (mode)
        0:       tt_res[i] = (tts[i] == 3'd1) ? {3'd0, 3'd7, 1'b1} : {3'd0, ttsy[i], 1'b1};
        1:       tt_res[i] = {3'd2, 3'd5, 1'b0};
        2:       tt_res[i] = {tts[i], ttsy[i] + 3'd1, 1'b1};
        default: tt_res[i] = {rt_ns[tts[i]][ttsy[i]], rt_ws[tts[i]][ttsy[i]], rt_dir[tts[i]][ttsy[i]]};
      endcase
    end
  end

  tm_tape_engine dut (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_raddr(cfg_raddr), .cfg_rdata(rdata_o[0]),
    .start(start), .start_state(start_state), .start_head(start_head),
    .free_run(free_run), .step_req(step_req), .abort(abort),
    .tt_state(tts[0]), .tt_sym(ttsy[0]), .tt_next_state(tt_res[0][6:4]),
    .tt_write_sym(tt_res[0][3:1]), .tt_dir(tt_res[0][0]),
    .busy(busy_o[0]), .halted(halted_o[0]), .fault(fault_o[0]), .fault_code(code_o[0]),
    .state(st_o[0]), .head(hd_o[0]), .step_count(cnt_o[0])
  );

  tm_tape_engine #(.WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_raddr(cfg_raddr), .cfg_rdata(rdata_o[1]),
    .start(start), .start_state(start_state), .start_head(start_head),
    .free_run(free_run), .step_req(step_req), .abort(abort),
    .tt_state(tts[1]), .tt_sym(ttsy[1]), .tt_next_state(tt_res[1][6:4]),
    .tt_write_sym(tt_res[1][3:1]), .tt_dir(tt_res[1][0]),
    .busy(busy_o[1]), .halted(halted_o[1]), .fault(fault_o[1]), .fault_code(code_o[1]),
    .state(st_o[1]), .head(hd_o[1]), .step_count(cnt_o[1])
  );

  tm_tape_engine #(.MAX_STEPS(5)) dut_lim (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_raddr(cfg_raddr), .cfg_rdata(rdata_o[2]),
    .start(start), .start_state(start_state), .start_head(start_head),
    .free_run(free_run), .step_req(step_req), .abort(abort),
    .tt_state(tts[2]), .tt_sym(ttsy[2]), .tt_next_state(tt_res[2][6:4]),
    .tt_write_sym(tt_res[2][3:1]), .tt_dir(tt_res[2][0]),
    .busy(busy_o[2]), .halted(halted_o[2]), .fault(fault_o[2]), .fault_code(code_o[2]),
    .state(st_o[2]), .head(hd_o[2]), .step_count(cnt_o[2])
  );

  typedef struct {
    int         mode;
    logic [2:0] s;
    logic [4:0] h;
    logic       eh;
    logic       ef;
    logic [1:0] ec;
    logic [4:0] ehd;
    logic [2:0] est;
    int         ecnt;
    logic [4:0] addr;
    logic [2:0] esym;
  } vec_t;

  vec_t vecs [6];

  logic [2:0] m_tape [32];
  logic [2:0] m_state;
  int         m_head;
  int         m_cnt;
  logic       m_halt;
  logic       m_fault;
  logic [1:0] m_code;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic read_cell(input int idx, input logic [4:0] a, output logic [2:0] v);
    cfg_raddr = a;
    #1;
    v = rdata_o[idx];
  endtask

  // Tape 0..3 = 1,2,3,4, rest 0; cell 3 is written on the same edge as start.
  task automatic begin_run(input int m, input logic [2:0] s, input logic [4:0] h, input logic fr);
    do_abort();
    mode = m;
    for (int a = 0; a < 32; a++) begin
      if (a != 3) begin
        cfg_we    = 1'b1;
        cfg_addr  = 5'(a);
        cfg_wdata = (a < 4) ? 3'(a + 1) : 3'd0;
        tick();
      end
    end
    cfg_we      = 1'b1;
    cfg_addr    = 5'd3;
    cfg_wdata   = 3'd4;
    start       = 1'b1;
    start_state = s;
    start_head  = h;
    free_run    = fr;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int idx, output int cyc);
    cyc = 0;
    while (busy_o[idx] && cyc < 200) begin
      tick();
      cyc++;
    end
    check("wait_idle_busy", 32'(busy_o[idx]), 32'd0);
  endtask

  // Behavioural step model for the 5-step-limit, non-wrapping build.
  task automatic model_run(input logic [2:0] s0, input int h0);
    logic [2:0] sy, ns, ws;
    logic       dr;
    int         nh;
    m_state = s0;
    m_head  = h0;
    m_cnt   = 0;
    m_halt  = (s0 == 3'd0);
    m_fault = 1'b0;
    m_code  = 2'd0;
    while (!m_halt && !m_fault) begin
      sy = m_tape[m_head];
      ns = rt_ns[m_state][sy];
      ws = rt_ws[m_state][sy];
      dr = rt_dir[m_state][sy];
      m_tape[m_head] = ws;
      m_state = ns;
      m_cnt++;
      nh = dr ? m_head + 1 : m_head - 1;
      if (nh >= 0 && nh < 32) m_head = nh;
      if (ns == 3'd0) m_halt = 1'b1;
      else if (nh < 0 || nh >= 32) begin m_fault = 1'b1; m_code = 2'd1; end
      else if (m_cnt == 5) begin m_fault = 1'b1; m_code = 2'd2; end
    end
  endtask

  initial begin
    int         cyc;
    int         nz;
    logic [2:0] v;
    logic [2:0] rs;
    int         rh;

    vecs[0] = '{0, 3'd1, 5'd0,  1'b1, 1'b0, 2'd0, 5'd1,  3'd0, 1,  5'd0,  3'd7};
    vecs[1] = '{1, 3'd2, 5'd0,  1'b0, 1'b1, 2'd1, 5'd0,  3'd2, 1,  5'd0,  3'd5};
    vecs[2] = '{0, 3'd0, 5'd5,  1'b1, 1'b0, 2'd0, 5'd5,  3'd0, 0,  5'd0,  3'd1};
    vecs[3] = '{1, 3'd2, 5'd3,  1'b0, 1'b1, 2'd1, 5'd0,  3'd2, 4,  5'd3,  3'd5};
    vecs[4] = '{2, 3'd3, 5'd28, 1'b0, 1'b1, 2'd1, 5'd31, 3'd3, 4,  5'd31, 3'd1};
    vecs[5] = '{2, 3'd3, 5'd3,  1'b0, 1'b1, 2'd1, 5'd31, 3'd3, 29, 5'd3,  3'd5};

    mode = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        rt_ns[a][b] = 3'd0; rt_ws[a][b] = 3'd0; rt_dir[a][b] = 1'b0;
      end
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_raddr = '0;
    start = 1'b0; start_state = '0; start_head = '0; free_run = 1'b0; step_req = 1'b0;
    abort = 1'b0;
    #12;
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    check("reset_halted", 32'(halted_o[0]), 32'd0);
    check("reset_code", 32'(code_o[0]), 32'd0);
    check("reset_cnt", 32'(cnt_o[0]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      begin_run(vecs[i].mode, vecs[i].s, vecs[i].h, 1'b1);
      wait_idle(0, cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(2 * vecs[i].ecnt));
      check($sformatf("v%0d_halted", i), 32'(halted_o[0]), 32'(vecs[i].eh));
      check($sformatf("v%0d_fault", i), 32'(fault_o[0]), 32'(vecs[i].ef));
      check($sformatf("v%0d_code", i), 32'(code_o[0]), 32'(vecs[i].ec));
      check($sformatf("v%0d_head", i), 32'(hd_o[0]), 32'(vecs[i].ehd));
      check($sformatf("v%0d_state", i), 32'(st_o[0]), 32'(vecs[i].est));
      check($sformatf("v%0d_cnt", i), 32'(cnt_o[0]), 32'(vecs[i].ecnt));
      read_cell(0, vecs[i].addr, v);
      check($sformatf("v%0d_tape", i), 32'(v), 32'(vecs[i].esym));
    end

    // Left move from cell 0: wrapping build keeps running, plain build faults.
    begin_run(1, 3'd2, 5'd0, 1'b1);
    tick();
    tick();
    check("wrap_head", 32'(hd_o[1]), 32'd31);
    check("wrap_busy", 32'(busy_o[1]), 32'd1);
    check("wrap_fault", 32'(fault_o[1]), 32'd0);
    check("edge_fault", 32'(fault_o[0]), 32'd1);
    check("edge_code", 32'(code_o[0]), 32'd1);
    check("edge_head", 32'(hd_o[0]), 32'd0);
    read_cell(0, 5'd0, v);
    check("edge_tape0", 32'(v), 32'd5);
    repeat (4) tick();
    check("wrap_busy_later", 32'(busy_o[1]), 32'd1);
    check("wrap_fault_later", 32'(fault_o[1]), 32'd0);

    // Step limit of 5 on a never-halting counter.
    begin_run(2, 3'd3, 5'd0, 1'b1);
    wait_idle(2, cyc);
    check("lim_cycles", 32'(cyc), 32'd10);
    check("lim_fault", 32'(fault_o[2]), 32'd1);
    check("lim_code", 32'(code_o[2]), 32'd2);
    check("lim_cnt", 32'(cnt_o[2]), 32'd5);
    check("lim_head", 32'(hd_o[2]), 32'd5);
    repeat (4) tick();
    check("lim_sticky_fault", 32'(fault_o[2]), 32'd1);
    check("lim_sticky_code", 32'(code_o[2]), 32'd2);
    start = 1'b1; start_state = 3'd3; start_head = 5'd10;
    tick();
    start = 1'b0;
    check("lim_restart_fault", 32'(fault_o[2]), 32'd0);
    check("lim_restart_code", 32'(code_o[2]), 32'd0);
    check("lim_restart_busy", 32'(busy_o[2]), 32'd1);
    check("lim_restart_cnt", 32'(cnt_o[2]), 32'd0);

    // Single-step: nothing advances without step_req.
    begin_run(2, 3'd3, 5'd0, 1'b0);
    repeat (4) tick();
    check("ss_idle_cnt", 32'(cnt_o[0]), 32'd0);
    check("ss_idle_busy", 32'(busy_o[0]), 32'd1);
    cfg_we = 1'b1; cfg_addr = 5'd20; cfg_wdata = 3'd6;
    tick();
    cfg_we = 1'b0;
    read_cell(0, 5'd20, v);
    check("ss_busy_write_ignored", 32'(v), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick();
      check($sformatf("ss_cnt_after_pulse%0d", k), 32'(cnt_o[0]), 32'(k));
      repeat (3) tick();
      check($sformatf("ss_cnt_hold%0d", k), 32'(cnt_o[0]), 32'(k));
    end
    check("ss_head", 32'(hd_o[0]), 32'd3);

    // Abort and start together: abort wins, run context preserved.
    abort = 1'b1; start = 1'b1; start_state = 3'd1; start_head = 5'd9;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abst_busy", 32'(busy_o[0]), 32'd0);
    check("abst_head", 32'(hd_o[0]), 32'd3);
    check("abst_state", 32'(st_o[0]), 32'd3);
    check("abst_cnt", 32'(cnt_o[0]), 32'd3);
    check("abst_halted", 32'(halted_o[0]), 32'd0);
    tick();
    check("abst_busy_later", 32'(busy_o[0]), 32'd0);

    // Random tables on the step-limited build.
    for (int it = 0; it < 8; it++) begin
      do_abort();
      mode = 3;
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          rt_ns[a][b]  = 3'($urandom_range(7));
          rt_ws[a][b]  = 3'($urandom_range(7));
          rt_dir[a][b] = 1'($urandom_range(1));
        end
      for (int a = 0; a < 32; a++) begin
        m_tape[a] = 3'($urandom_range(7));
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_wdata = m_tape[a];
        tick();
      end
      cfg_we = 1'b0;
      rs = 3'($urandom_range(7));
      rh = int'($urandom_range(31));
      start = 1'b1; start_state = rs; start_head = 5'(rh); free_run = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(2, cyc);
      model_run(rs, rh);
      check($sformatf("r%0d_cycles", it), 32'(cyc), 32'(2 * m_cnt));
      check($sformatf("r%0d_halted", it), 32'(halted_o[2]), 32'(m_halt));
      check($sformatf("r%0d_code", it), 32'(code_o[2]), 32'(m_code));
      check($sformatf("r%0d_state", it), 32'(st_o[2]), 32'(m_state));
      check($sformatf("r%0d_head", it), 32'(hd_o[2]), 32'(m_head));
      check($sformatf("r%0d_cnt", it), 32'(cnt_o[2]), 32'(m_cnt));
      nz = 0;
      for (int a = 0; a < 32; a++) begin
        read_cell(2, 5'(a), v);
        if (v !== m_tape[a]) nz++;
      end
      check($sformatf("r%0d_tape_diffs", it), 32'(nz), 32'd0);
    end

    // Asynchronous reset while in COMMIT.
    begin_run(2, 3'd3, 5'd0, 1'b1);
    tick();
    check("rst_pre_busy", 32'(busy_o[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy_o[0]), 32'd0);
    check("rst_halted", 32'(halted_o[0]), 32'd0);
    check("rst_fault", 32'(fault_o[0]), 32'd0);
    check("rst_code", 32'(code_o[0]), 32'd0);
    check("rst_state", 32'(st_o[0]), 32'd0);
    check("rst_head", 32'(hd_o[0]), 32'd0);
    check("rst_cnt", 32'(cnt_o[0]), 32'd0);
    check("rst_ttsym", 32'(ttsy[0]), 32'd0);
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      read_cell(0, 5'(a), v);
      if (v !== 3'd0) nz++;
    end
    check("rst_tape_nonzero", 32'(nz), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
